// File: rtl/ram_burst_tracker.sv
// ram_burst_tracker
//   Rebuilds synchronous RAM burst transactions from the strobe-qualified
//   samples produced by ram_sampler. Each data word becomes one record
//   {addr, data, byte lanes, direction, index}. Records are queued in a small
//   FIFO and drained toward the trace packetizer over a valid/ready handshake.
//   Optional feature macro: RAM_BURST_NFILTER_EN makes read records take their
//   data from the negedge-sampled bus (nfilter_d). Writes always use filter_d.
module ram_burst_tracker #(
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned FIFO_LOG2 = 3,
   parameter int unsigned IDX_W     = 8
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic [22:0]      filter_a,
   input  logic [15:0]      filter_d,
   input  logic [15:0]      nfilter_d,
   input  logic [1:0]       filter_ublb,
   input  logic             filter_read,
   input  logic             filter_write,
   input  logic             filter_addr_latch,
   input  logic             filter_strobe,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [22:0]      out_addr,
   output logic [15:0]      out_data,
   output logic [1:0]       out_ublb,
   output logic             out_write,
   output logic [IDX_W-1:0] out_idx,
   output logic             overflow
);

   localparam int unsigned      DEPTH    = 1 << FIFO_LOG2;
   localparam int unsigned      CNT_W    = FIFO_LOG2 + 1;
   localparam logic [3:0]       LAT_LOAD = 4'(LATENCY - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   typedef struct packed {
      logic [22:0]      addr;
      logic [15:0]      data;
      logic [1:0]       ublb;
      logic             write;
      logic [IDX_W-1:0] idx;
   } rec_t;

   // Burst tracking state
   state_t           state, state_nx;
   logic [22:0]      base, base_nx;
   logic [3:0]       lat_cnt, lat_nx;
   logic [IDX_W-1:0] idx, idx_nx, idx_inc;
   logic             push;
   logic             any_rw;
   logic [15:0]      rec_data;
   rec_t             rec;

   // FIFO state
   rec_t                 mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr, rd_last;
   logic [CNT_W-1:0]     count;
   logic                 full, pop, accept;
   rec_t                 head;

   assign any_rw  = filter_read | filter_write;
   assign idx_inc = (idx == IDX_MAX) ? idx : idx + 1'b1;

`ifdef RAM_BURST_NFILTER_EN
   // Reads (write low) carry data driven on the falling edge.
   assign rec_data = filter_write ? filter_d : nfilter_d;
`else
   logic unused_nfilter;
   assign unused_nfilter = ^nfilter_d;
   assign rec_data       = filter_d;
`endif

   // Assemble the record for the current strobe; read&&write counts as write.
   always_comb begin
      rec       = '0;
      rec.addr  = base + 23'(idx);
      rec.data  = rec_data;
      rec.ublb  = filter_ublb;
      rec.write = filter_write;
      rec.idx   = idx;
   end

   // Burst FSM state register with asynchronous reset.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         base    <= '0;
         lat_cnt <= '0;
         idx     <= '0;
      end else begin
         state   <= state_nx;
         base    <= base_nx;
         lat_cnt <= lat_nx;
         idx     <= idx_nx;
      end
   end

   // Next-state logic; only strobe cycles advance the tracker.
   // The WAIT strobe that finds lat_cnt at zero is itself the first data word,
   // so exactly LATENCY strobes separate the ADV strobe from the first record.
   always_comb begin
      state_nx = state;
      base_nx  = base;
      lat_nx   = lat_cnt;
      idx_nx   = idx;
      push     = 1'b0;
      if (filter_strobe) begin
         case (state)
            S_IDLE: begin
               if (filter_addr_latch) begin
                  state_nx = S_WAIT;
                  base_nx  = filter_a;
                  lat_nx   = LAT_LOAD;
                  idx_nx   = '0;
               end
            end
            S_WAIT: begin
               if (filter_addr_latch) begin
                  base_nx = filter_a;
                  lat_nx  = LAT_LOAD;
                  idx_nx  = '0;
               end else if (!any_rw) begin
                  state_nx = S_IDLE;
               end else if (lat_cnt == '0) begin
                  push     = 1'b1;
                  idx_nx   = idx_inc;
                  state_nx = S_BURST;
               end else begin
                  lat_nx = lat_cnt - 4'd1;
               end
            end
            S_BURST: begin
               if (filter_addr_latch) begin
                  state_nx = S_WAIT;
                  base_nx  = filter_a;
                  lat_nx   = LAT_LOAD;
                  idx_nx   = '0;
               end else if (any_rw) begin
                  push   = 1'b1;
                  idx_nx = idx_inc;
               end else begin
                  state_nx = S_IDLE;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign accept    = push & (~full | pop);
   assign rd_last   = rd_ptr - 1'b1;

   // Slots are never cleared on pop, so the slot behind rd_ptr still holds the
   // last popped record and provides the hold value while the FIFO is empty.
   assign head      = out_valid ? mem[rd_ptr] : mem[rd_last];
   assign out_addr  = head.addr;
   assign out_data  = head.data;
   assign out_ublb  = head.ublb;
   assign out_write = head.write;
   assign out_idx   = head.idx;

   // Record FIFO storage, pointers, occupancy and sticky overflow flag.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         mem      <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= rec;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !accept) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_burst_tracker.sv
// Scoreboard bench for ram_burst_tracker (LATENCY=4, FIFO_LOG2=3, IDX_W=8).
// Stimulus pushes hand-computed records into exp_q; the monitor pops and
// compares on every accepted handshake.
module tb_ram_burst_tracker;

   logic        mclk = 1'b0;
   logic        reset_n;
   logic [22:0] filter_a;
   logic [15:0] filter_d;
   logic [15:0] nfilter_d;
   logic [1:0]  filter_ublb;
   logic        filter_read;
   logic        filter_write;
   logic        filter_addr_latch;
   logic        filter_strobe;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] out_addr;
   logic [15:0] out_data;
   logic [1:0]  out_ublb;
   logic        out_write;
   logic [7:0]  out_idx;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   logic [49:0] exp_q[$];
   logic [49:0] mon_act, mon_exp;

   ram_burst_tracker #(.LATENCY(4), .FIFO_LOG2(3), .IDX_W(8)) dut (
      .mclk              (mclk),
      .reset_n           (reset_n),
      .filter_a          (filter_a),
      .filter_d          (filter_d),
      .nfilter_d         (nfilter_d),
      .filter_ublb       (filter_ublb),
      .filter_read       (filter_read),
      .filter_write      (filter_write),
      .filter_addr_latch (filter_addr_latch),
      .filter_strobe     (filter_strobe),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_addr          (out_addr),
      .out_data          (out_data),
      .out_ublb          (out_ublb),
      .out_write         (out_write),
      .out_idx           (out_idx),
      .overflow          (overflow)
   );

   always #5 mclk = ~mclk;

   function automatic logic [15:0] rd_exp(input logic [15:0] d);
`ifdef RAM_BURST_NFILTER_EN
      return ~d;
`else
      return d;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic exp_rec(input logic [22:0] a, input logic [15:0] d, input logic [1:0] ub,
                          input logic w, input logic [7:0] ix);
      exp_q.push_back({a, d, ub, w, ix});
   endtask

   task automatic strobe(input logic [22:0] a, input logic [15:0] d, input logic [15:0] nd,
                         input logic [1:0] ub, input logic r, input logic w, input logic adv);
      filter_a          = a;
      filter_d          = d;
      nfilter_d         = nd;
      filter_ublb       = ub;
      filter_read       = r;
      filter_write      = w;
      filter_addr_latch = adv;
      filter_strobe     = 1'b1;
      @(posedge mclk);
      #1 filter_strobe  = 1'b0;
   endtask

   task automatic latch(input logic [22:0] a);
      strobe(a, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic wait3(input logic r, input logic w);
      repeat (3) strobe(23'h000ABC, 16'hDEAD, 16'hBEEF, 2'b11, r, w, 1'b0);
   endtask

   task automatic rd(input logic [15:0] d);
      strobe(23'h012345, d, ~d, 2'b11, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic endb();
      strobe(23'h000000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge mclk);
         n++;
      end
      #1;
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      @(posedge mclk);
      #1 reset_n = 1'b1;
   endtask

   // Monitor: every accepted record must match the head of the scoreboard.
   always @(negedge mclk) begin
      if (reset_n && out_valid && out_ready) begin
         mon_act = {out_addr, out_data, out_ublb, out_write, out_idx};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rec_unexpected act=%h exp=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL rec act addr=%h data=%h ublb=%b wr=%b idx=%0d exp addr=%h data=%h ublb=%b wr=%b idx=%0d",
                        out_addr, out_data, out_ublb, out_write, out_idx,
                        mon_exp[49:27], mon_exp[26:11], mon_exp[10:9], mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n           = 1'b0;
      out_ready         = 1'b0;
      filter_a          = '0;
      filter_d          = '0;
      nfilter_d         = '0;
      filter_ublb       = '0;
      filter_read       = 1'b0;
      filter_write      = 1'b0;
      filter_addr_latch = 1'b0;
      filter_strobe     = 1'b0;
      repeat (2) @(posedge mclk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_outs", 64'({out_addr, out_data, out_ublb, out_write, out_idx}), 64'd0);
      reset_n = 1'b1;
      idle(1);

      // Read burst at 0x001000, with a strobe-free gap mid-burst
      out_ready = 1'b1;
      latch(23'h001000);
      wait3(1'b1, 1'b0);
      exp_rec(23'h001000, rd_exp(16'h00A0), 2'b11, 1'b0, 8'd0);
      rd(16'h00A0);
      check("first_latency_valid", 64'(out_valid), 64'd1);
      exp_rec(23'h001001, rd_exp(16'h00A1), 2'b11, 1'b0, 8'd1);
      rd(16'h00A1);
      idle(2);
      exp_rec(23'h001002, rd_exp(16'h00A2), 2'b11, 1'b0, 8'd2);
      rd(16'h00A2);
      exp_rec(23'h001003, rd_exp(16'h00A3), 2'b11, 1'b0, 8'd3);
      rd(16'h00A3);
      endb();
      wait_drain();

      // Write burst wrapping the 23-bit address space
      latch(23'h7FFFFE);
      wait3(1'b0, 1'b1);
      exp_rec(23'h7FFFFE, 16'h00B0, 2'b11, 1'b1, 8'd0);
      strobe(23'h000001, 16'h00B0, 16'h1234, 2'b11, 1'b0, 1'b1, 1'b0);
      exp_rec(23'h7FFFFF, 16'h00B1, 2'b10, 1'b1, 8'd1);
      strobe(23'h000001, 16'h00B1, 16'h1234, 2'b10, 1'b0, 1'b1, 1'b0);
      exp_rec(23'h000000, 16'h00B2, 2'b01, 1'b1, 8'd2);
      strobe(23'h000001, 16'h00B2, 16'h1234, 2'b01, 1'b0, 1'b1, 1'b0);
      endb();
      wait_drain();

      // Overflow: 10 words into an 8-deep FIFO with the consumer stalled
      out_ready = 1'b0;
      latch(23'h000100);
      wait3(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_rec(23'h000100 + 23'(i), rd_exp(16'h00C0 + 16'(i)), 2'b11, 1'b0, 8'(i));
         rd(16'h00C0 + 16'(i));
      end
      endb();
      idle(2);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_valid", 64'(out_valid), 64'd1);
      check("stall_head", 64'({out_addr, out_data, out_idx}),
            64'({23'h000100, rd_exp(16'h00C0), 8'd0}));
      idle(3);
      check("stall_stable", 64'({out_addr, out_data, out_idx}),
            64'({23'h000100, rd_exp(16'h00C0), 8'd0}));
      out_ready = 1'b1;
      wait_drain();
      idle(2);
      check("drained_valid", 64'(out_valid), 64'd0);
      check("hold_last", 64'({out_addr, out_data, out_idx}),
            64'({23'h000107, rd_exp(16'h00C7), 8'd7}));
      check("ovf_sticky", 64'(overflow), 64'd1);

      // Full FIFO with simultaneous pop and push: nothing dropped
      do_reset();
      check("reset_clears_ovf", 64'(overflow), 64'd0);
      out_ready = 1'b0;
      latch(23'h000300);
      wait3(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_rec(23'h000300 + 23'(i), rd_exp(16'h00D0 + 16'(i)), 2'b11, 1'b0, 8'(i));
         rd(16'h00D0 + 16'(i));
      end
      idle(1);
      check("full_ovf_before", 64'(overflow), 64'd0);
      out_ready = 1'b1;
      exp_rec(23'h000308, rd_exp(16'h00D8), 2'b11, 1'b0, 8'd8);
      rd(16'h00D8);
      endb();
      wait_drain();
      check("full_popush_ovf", 64'(overflow), 64'd0);

      // New ADV mid-burst restarts the transaction; abort in WAIT
      latch(23'h000400);
      wait3(1'b1, 1'b0);
      exp_rec(23'h000400, rd_exp(16'h00E0), 2'b11, 1'b0, 8'd0);
      rd(16'h00E0);
      exp_rec(23'h000401, rd_exp(16'h00E1), 2'b11, 1'b0, 8'd1);
      rd(16'h00E1);
      latch(23'h000200);
      wait3(1'b1, 1'b0);
      exp_rec(23'h000200, rd_exp(16'h00E2), 2'b11, 1'b0, 8'd0);
      rd(16'h00E2);
      exp_rec(23'h000201, rd_exp(16'h00E3), 2'b11, 1'b0, 8'd1);
      rd(16'h00E3);
      endb();
      wait_drain();
      latch(23'h000500);
      strobe(23'h000000, 16'h0000, 16'h0000, 2'b11, 1'b1, 1'b0, 1'b0);
      endb();
      for (int i = 0; i < 4; i++) rd(16'h00F0 + 16'(i));
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("abort_no_rec", 64'(out_valid), 64'd0);
      end

      // Data source selection for reads; read&&write is a write
      latch(23'h000600);
      wait3(1'b1, 1'b0);
`ifdef RAM_BURST_NFILTER_EN
      exp_rec(23'h000600, 16'h5A5A, 2'b11, 1'b0, 8'd0);
`else
      exp_rec(23'h000600, 16'h1111, 2'b11, 1'b0, 8'd0);
`endif
      strobe(23'h000000, 16'h1111, 16'h5A5A, 2'b11, 1'b1, 1'b0, 1'b0);
      exp_rec(23'h000601, 16'h2222, 2'b10, 1'b1, 8'd1);
      strobe(23'h000000, 16'h2222, 16'h3333, 2'b10, 1'b1, 1'b1, 1'b0);
      endb();
      wait_drain();

      // Asynchronous reset mid-burst with records queued
      out_ready = 1'b0;
      latch(23'h000700);
      wait3(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) rd(16'h0070 + 16'(i));
      idle(1);
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_outs", 64'({out_addr, out_data, out_idx}), 64'd0);
      @(posedge mclk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) rd(16'h0090 + 16'(i));
      idle(2);
      check("post_reset_idle", 64'(out_valid), 64'd0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
